mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  Memory-access pipeline stage plus MEM/WB register; sits between EX/MEM and the writeback stage.
//  Drives data memory over a req/ready handshake, builds store byte-enables, aligns and extends load data.
//  Stalls the pipe while memory is busy, and flags misaligned, illegal and timed-out accesses.
//  Registered mem_wb_* outputs feed writeback directly; mem_wb_load_data drives its load-data input.
// PARAMETERS
//  ALIGN_CHECK     1    1: misaligned H/W access raises mem_fault_o, no request. 0: addr low bits ignored.
//  TIMEOUT_CYCLES  255  Max WAIT cycles before abort; 0 disables timeout (counter width $clog2(N+1)).
// PORTS
//  clk                 in   1     clock
//  rst                 in   1     synchronous, active-high reset
//  ex_mem_valid        in   1     instruction present in EX/MEM
//  ex_mem_mem_read     in   1     load
//  ex_mem_mem_write    in   1     store
//  ex_mem_funct3       in   3     width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  ex_mem_alu_result   in   XLEN  effective address / ALU result
//  ex_mem_rs2_data     in   XLEN  store data
//  ex_mem_mem_to_reg   in   2     WB select, passed through
//  ex_mem_reg_write    in   1     passed through (may be forced 0)
//  ex_mem_rd           in   5     destination register
//  ex_mem_pc_plus_4    in   XLEN  passed through
//  dmem_req            out  1     access request
//  dmem_we             out  1     1 store, 0 load
//  dmem_addr           out  XLEN  word-aligned address ({addr[XLEN-1:2],2'b00})
//  dmem_wdata          out  XLEN  lane-replicated store data
//  dmem_be             out  4     byte enables (0 for loads)
//  dmem_ready          in   1     access completes this cycle
//  dmem_rdata          in   XLEN  read word, valid when dmem_ready
//  mem_stall           out  1     freeze IF..EX/MEM this cycle
//  mem_fault_o         out  1     1-cycle registered pulse: misaligned/illegal/timeout
//  mem_wb_valid, mem_wb_reg_write, mem_wb_rd[5], mem_wb_mem_to_reg[2]   out  registered
//  mem_wb_alu_result, mem_wb_pc_plus_4, mem_wb_load_data   out  XLEN  registered
// BEHAVIOUR
//  Reset: FSM IDLE, timeout counter 0, all mem_wb_* and mem_fault_o 0; dmem_req forced 0 in any rst cycle.
//  Mem op = ex_mem_valid & (mem_read|mem_write). Fault = illegal funct3 (011,110,111) or ALIGN_CHECK
//   & (H & addr[0] | W & addr[1:0]!=0). Faulting op: no dmem_req, mem_fault_o=1 next cycle, reg_write forced 0.
//  FSM IDLE: legal mem op -> dmem_req=1 combinationally. dmem_ready same cycle -> complete, no stall
//   (zero-wait). Else -> WAIT, mem_stall=1.
//  FSM WAIT: dmem_req=1, mem_stall=1, all dmem_* held stable (EX/MEM frozen by stall); counter++.
//   dmem_ready -> complete, mem_stall=0 that cycle, -> IDLE, counter=0.
//   Counter reaches TIMEOUT_CYCLES without ready -> abort: dmem_req=0, complete as fault, -> IDLE.
//  dmem_ready seen outside a request is ignored. req never drops in WAIT before ready/timeout.
//  Store: B be=4'b0001<<a[1:0], wdata={4{rs2[7:0]}}; H be=4'b0011<<{a[1],1'b0}, wdata={2{rs2[15:0]}}; W be=F.
//  Load: byte/half selected by a[1:0]/a[1], sign-ext (B,H) or zero-ext (BU,HU), W passthrough;
//   registered into mem_wb_load_data at completion; 0 for non-loads.
//  MEM/WB register: when !mem_stall, capture ex_mem_* (valid, reg_write & !fault, rd, mem_to_reg,
//   alu_result, pc_plus_4). When mem_stall, insert bubble: mem_wb_valid=0, mem_wb_reg_write=0.
//  Non-memory valid ops pass through in 1 cycle, no stall. Latency for any op: 1 cycle after completion.
//  Reset mid-WAIT: request abandoned, no writeback, no fault pulse.
//  XLEN must be 32 (elaboration $error otherwise).
// STRUCTURE
//  riscv_pkg: XLEN, funct3 width localparams (F3_B/H/W/BU/HU), mem_state_t enum {MEM_IDLE, MEM_WAIT}.
//  One sub-module: lsu_align (combinational: be/wdata generation, load extract/extend, fault detect).
//  FSM, timeout counter, MEM/WB register in top.
// TESTING
//  SW addr 0x104, rs2 0xDEADBEEF, ready same cycle -> be=F, wdata=0xDEADBEEF, mem_stall never 1.
//  LB addr 0x103, rdata 0x80FF_FF7F, ready after 3 cycles -> stall 3 cycles, 3 bubbles, load_data=0xFFFFFF80.
//  LHU addr 0x102, rdata 0x8001_1234 -> load_data=0x00008001; SH 0x102 rs2 0xABCD -> be=1100, wdata=0xABCDABCD.
//  LW addr 0x101 (ALIGN_CHECK=1) -> no dmem_req, mem_fault_o pulse, mem_wb_reg_write=0.
//  TIMEOUT_CYCLES=4, ready never -> req held 4 WAIT cycles, then dropped, fault pulse, pipe resumes.
//  rst asserted in 2nd WAIT cycle -> next cycle req=0, state IDLE, all mem_wb_* 0, no fault.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the load/store path: data width, funct3 width codes
// and the memory-stage FSM states.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    MEM_IDLE,
    MEM_WAIT
  } mem_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational load/store lane logic: store byte-enables and lane replication,
// load byte/half extraction with sign or zero extension, and access fault detection.
module lsu_align
  import riscv_pkg::*;
#(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic            fault
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        illegal;
  logic        misaligned;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // funct3[1:0] gives the access size for stores; BU/HU share the B/H encodings
  always_comb begin
    be        = 4'b0000;
    wdata     = rs2_data;
    load_data = '0;
    case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{rs2_data[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << {addr_lo[1], 1'b0};
        wdata = {2{rs2_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = rs2_data;
      end
    endcase

    case (funct3)
      F3_B:    load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_H:    load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_W:    load_data = rdata;
      F3_BU:   load_data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_HU:   load_data = {{(XLEN-16){1'b0}}, half_sel};
      default: load_data = '0;
    endcase

    illegal    = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    misaligned = ALIGN_CHECK &&
                 (((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                  ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00)));
    fault      = illegal | misaligned;
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: data memory handshake FSM with timeout, stall generation,
// fault pulse and the MEM/WB pipeline register.
module mem_access_stage
  import riscv_pkg::*;
#(
  parameter bit ALIGN_CHECK    = 1'b1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_mem_valid,
  input  logic            ex_mem_mem_read,
  input  logic            ex_mem_mem_write,
  input  logic [2:0]      ex_mem_funct3,
  input  logic [XLEN-1:0] ex_mem_alu_result,
  input  logic [XLEN-1:0] ex_mem_rs2_data,
  input  logic [1:0]      ex_mem_mem_to_reg,
  input  logic            ex_mem_reg_write,
  input  logic [4:0]      ex_mem_rd,
  input  logic [XLEN-1:0] ex_mem_pc_plus_4,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            mem_stall,
  output logic            mem_fault_o,
  output logic            mem_wb_valid,
  output logic            mem_wb_reg_write,
  output logic [4:0]      mem_wb_rd,
  output logic [1:0]      mem_wb_mem_to_reg,
  output logic [XLEN-1:0] mem_wb_alu_result,
  output logic [XLEN-1:0] mem_wb_pc_plus_4,
  output logic [XLEN-1:0] mem_wb_load_data
);

  if (XLEN != 32) begin : g_xlen_check
    $error("mem_access_stage supports XLEN == 32 only");
  end

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  mem_state_t      state, state_next;
  logic [CW-1:0]   wait_cnt;
  logic [3:0]      lane_be;
  logic [XLEN-1:0] lane_wdata;
  logic [XLEN-1:0] lane_load;
  logic            lane_fault;
  logic            mem_op;
  logic            fault_op;
  logic            legal_op;
  logic            timeout_hit;
  logic            done_ok;
  logic            abort;
  logic            fault_now;

  lsu_align #(
    .ALIGN_CHECK(ALIGN_CHECK)
  ) u_lsu_align (
    .funct3    (ex_mem_funct3),
    .addr_lo   (ex_mem_alu_result[1:0]),
    .rs2_data  (ex_mem_rs2_data),
    .rdata     (dmem_rdata),
    .be        (lane_be),
    .wdata     (lane_wdata),
    .load_data (lane_load),
    .fault     (lane_fault)
  );

  assign mem_op      = ex_mem_valid & (ex_mem_mem_read | ex_mem_mem_write);
  assign fault_op    = mem_op & lane_fault;
  assign legal_op    = mem_op & ~lane_fault;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == CW'(TIMEOUT_CYCLES));
  assign fault_now   = fault_op | abort;

  // Address and data come straight from EX/MEM, which the stall keeps frozen during WAIT
  assign dmem_we    = ex_mem_mem_write;
  assign dmem_addr  = {ex_mem_alu_result[XLEN-1:2], 2'b00};
  assign dmem_wdata = lane_wdata;
  assign dmem_be    = ex_mem_mem_write ? lane_be : 4'b0000;

  always_comb begin
    state_next = state;
    dmem_req   = 1'b0;
    mem_stall  = 1'b0;
    done_ok    = 1'b0;
    abort      = 1'b0;
    if (!rst) begin
      case (state)
        MEM_IDLE: begin
          if (legal_op) begin
            dmem_req = 1'b1;
            if (dmem_ready) begin
              done_ok = 1'b1;
            end else begin
              mem_stall  = 1'b1;
              state_next = MEM_WAIT;
            end
          end
        end
        MEM_WAIT: begin
          if (timeout_hit) begin
            abort      = 1'b1;
            state_next = MEM_IDLE;
          end else begin
            dmem_req = 1'b1;
            if (dmem_ready) begin
              done_ok    = 1'b1;
              state_next = MEM_IDLE;
            end else begin
              mem_stall = 1'b1;
            end
          end
        end
        default: state_next = MEM_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= MEM_IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if ((state == MEM_WAIT) && mem_stall) begin
        wait_cnt <= wait_cnt + CW'(1);
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  // Stalled cycles push a bubble into writeback; everything else moves one stage on
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_fault_o       <= 1'b0;
      mem_wb_valid      <= 1'b0;
      mem_wb_reg_write  <= 1'b0;
      mem_wb_rd         <= '0;
      mem_wb_mem_to_reg <= '0;
      mem_wb_alu_result <= '0;
      mem_wb_pc_plus_4  <= '0;
      mem_wb_load_data  <= '0;
    end else begin
      mem_fault_o <= fault_now;
      if (mem_stall) begin
        mem_wb_valid     <= 1'b0;
        mem_wb_reg_write <= 1'b0;
      end else begin
        mem_wb_valid      <= ex_mem_valid;
        mem_wb_reg_write  <= ex_mem_reg_write & ~fault_now;
        mem_wb_rd         <= ex_mem_rd;
        mem_wb_mem_to_reg <= ex_mem_mem_to_reg;
        mem_wb_alu_result <= ex_mem_alu_result;
        mem_wb_pc_plus_4  <= ex_mem_pc_plus_4;
        mem_wb_load_data  <= (done_ok && ex_mem_mem_read) ? lane_load : '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed loads/stores, faults, timeout and
// reset during WAIT; a negedge monitor checks every MEM/WB result against the queue.
module tb_mem_access_stage;
  import riscv_pkg::*;

  localparam int TMO = 4;

  typedef struct {
    logic [4:0]  rd;
    logic        reg_write;
    logic [1:0]  m2r;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] load;
    logic        fault;
  } wb_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_mem_valid, ex_mem_mem_read, ex_mem_mem_write;
  logic [2:0]  ex_mem_funct3;
  logic [31:0] ex_mem_alu_result, ex_mem_rs2_data, ex_mem_pc_plus_4;
  logic [1:0]  ex_mem_mem_to_reg;
  logic        ex_mem_reg_write;
  logic [4:0]  ex_mem_rd;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        mem_stall, mem_fault_o;
  logic        mem_wb_valid, mem_wb_reg_write;
  logic [4:0]  mem_wb_rd;
  logic [1:0]  mem_wb_mem_to_reg;
  logic [31:0] mem_wb_alu_result, mem_wb_pc_plus_4, mem_wb_load_data;

  wb_exp_t     sb[$];
  wb_exp_t     mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] pc_next  = 32'h0000_1000;

  always #5 clk = ~clk;

  mem_access_stage #(
    .ALIGN_CHECK(1'b1),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .ex_mem_valid      (ex_mem_valid),
    .ex_mem_mem_read   (ex_mem_mem_read),
    .ex_mem_mem_write  (ex_mem_mem_write),
    .ex_mem_funct3     (ex_mem_funct3),
    .ex_mem_alu_result (ex_mem_alu_result),
    .ex_mem_rs2_data   (ex_mem_rs2_data),
    .ex_mem_mem_to_reg (ex_mem_mem_to_reg),
    .ex_mem_reg_write  (ex_mem_reg_write),
    .ex_mem_rd         (ex_mem_rd),
    .ex_mem_pc_plus_4  (ex_mem_pc_plus_4),
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_addr         (dmem_addr),
    .dmem_wdata        (dmem_wdata),
    .dmem_be           (dmem_be),
    .dmem_ready        (dmem_ready),
    .dmem_rdata        (dmem_rdata),
    .mem_stall         (mem_stall),
    .mem_fault_o       (mem_fault_o),
    .mem_wb_valid      (mem_wb_valid),
    .mem_wb_reg_write  (mem_wb_reg_write),
    .mem_wb_rd         (mem_wb_rd),
    .mem_wb_mem_to_reg (mem_wb_mem_to_reg),
    .mem_wb_alu_result (mem_wb_alu_result),
    .mem_wb_pc_plus_4  (mem_wb_pc_plus_4),
    .mem_wb_load_data  (mem_wb_load_data)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    ex_mem_valid      = 1'b0;
    ex_mem_mem_read   = 1'b0;
    ex_mem_mem_write  = 1'b0;
    ex_mem_funct3     = F3_W;
    ex_mem_alu_result = '0;
    ex_mem_rs2_data   = '0;
    ex_mem_mem_to_reg = '0;
    ex_mem_reg_write  = 1'b0;
    ex_mem_rd         = '0;
    ex_mem_pc_plus_4  = '0;
    dmem_ready        = 1'b0;
    dmem_rdata        = '0;
  endtask

  // ready_delay: cycle index (0 = same cycle) at which dmem_ready rises; -1 = never
  task automatic applyStimulus(input string name, input bit rd_en, input bit wr_en,
                               input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] rs2, input logic [31:0] rdata,
                               input int ready_delay, input logic [4:0] rd, input bit legal,
                               input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                               input logic [31:0] exp_load, input bit exp_fault);
    wb_exp_t e;
    bit      done;
    bit      exp_req;
    bit      exp_stall;
    ex_mem_valid      = 1'b1;
    ex_mem_mem_read   = rd_en;
    ex_mem_mem_write  = wr_en;
    ex_mem_funct3     = f3;
    ex_mem_alu_result = addr;
    ex_mem_rs2_data   = rs2;
    ex_mem_mem_to_reg = rd_en ? 2'b01 : 2'b00;
    ex_mem_reg_write  = !wr_en;
    ex_mem_rd         = rd;
    ex_mem_pc_plus_4  = pc_next;
    dmem_rdata        = rdata;
    e.rd        = rd;
    e.reg_write = !wr_en && !exp_fault;
    e.m2r       = rd_en ? 2'b01 : 2'b00;
    e.alu       = addr;
    e.pc        = pc_next;
    e.load      = exp_load;
    e.fault     = exp_fault;
    sb.push_back(e);
    pc_next = pc_next + 32'd4;
    done = 1'b0;
    for (int k = 0; k < 32 && !done; k++) begin
      dmem_ready = (k == ready_delay);
      @(negedge clk);
      if (!legal) begin
        exp_req = 1'b0; exp_stall = 1'b0; done = 1'b1;
      end else if (k == ready_delay) begin
        exp_req = 1'b1; exp_stall = 1'b0; done = 1'b1;
      end else if (k == TMO + 1) begin
        exp_req = 1'b0; exp_stall = 1'b0; done = 1'b1;
      end else begin
        exp_req = 1'b1; exp_stall = 1'b1;
      end
      checkOutput({name, " req"}, 32'(dmem_req), 32'(exp_req));
      checkOutput({name, " stall"}, 32'(mem_stall), 32'(exp_stall));
      if (legal && exp_req) begin
        checkOutput({name, " addr"}, dmem_addr, addr & ~32'h3);
        checkOutput({name, " we"}, 32'(dmem_we), 32'(wr_en));
        checkOutput({name, " be"}, 32'(dmem_be), 32'(exp_be));
        if (wr_en) checkOutput({name, " wdata"}, dmem_wdata, exp_wdata);
      end
      if (k >= 1) checkOutput({name, " bubble"}, 32'(mem_wb_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    if (!done) checkOutput({name, " completion bound"}, 32'd0, 32'd1);
    clearInputs();
  endtask

  // Every valid MEM/WB entry must match the oldest pending expectation
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (mem_wb_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected writeback", 32'(mem_wb_valid), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("wb rd", 32'(mem_wb_rd), 32'(mon_e.rd));
          checkOutput("wb reg_write", 32'(mem_wb_reg_write), 32'(mon_e.reg_write));
          checkOutput("wb mem_to_reg", 32'(mem_wb_mem_to_reg), 32'(mon_e.m2r));
          checkOutput("wb alu_result", mem_wb_alu_result, mon_e.alu);
          checkOutput("wb pc_plus_4", mem_wb_pc_plus_4, mon_e.pc);
          checkOutput("wb load_data", mem_wb_load_data, mon_e.load);
          checkOutput("wb fault", 32'(mem_fault_o), 32'(mon_e.fault));
        end
      end else begin
        checkOutput("idle fault", 32'(mem_fault_o), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clearInputs();
    rst = 1'b1;
    ex_mem_valid    = 1'b1;
    ex_mem_mem_read = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset req", 32'(dmem_req), 32'd0);
    checkOutput("reset wb_valid", 32'(mem_wb_valid), 32'd0);
    checkOutput("reset fault", 32'(mem_fault_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clearInputs();

    dmem_ready = 1'b1;
    @(negedge clk);
    checkOutput("stray ready req", 32'(dmem_req), 32'd0);
    checkOutput("stray ready stall", 32'(mem_stall), 32'd0);
    @(posedge clk);
    #1;
    dmem_ready = 1'b0;

    applyStimulus("SW", 0, 1, F3_W, 32'h104, 32'hDEADBEEF, 32'h0, 0, 5'd0, 1,
                  4'b1111, 32'hDEADBEEF, 32'h0, 0);
    applyStimulus("LB", 1, 0, F3_B, 32'h103, 32'h0, 32'h80FF_FF7F, 3, 5'd5, 1,
                  4'b0000, 32'h0, 32'hFFFF_FF80, 0);
    applyStimulus("LHU", 1, 0, F3_HU, 32'h102, 32'h0, 32'h8001_1234, 1, 5'd6, 1,
                  4'b0000, 32'h0, 32'h0000_8001, 0);
    applyStimulus("SH", 0, 1, F3_H, 32'h102, 32'h0000_ABCD, 32'h0, 0, 5'd0, 1,
                  4'b1100, 32'hABCD_ABCD, 32'h0, 0);
    applyStimulus("LW misaligned", 1, 0, F3_W, 32'h101, 32'h0, 32'h0, 0, 5'd7, 0,
                  4'b0000, 32'h0, 32'h0, 1);
    applyStimulus("LH", 1, 0, F3_H, 32'h100, 32'h0, 32'h1234_8765, 0, 5'd8, 1,
                  4'b0000, 32'h0, 32'hFFFF_8765, 0);
    applyStimulus("LBU", 1, 0, F3_BU, 32'h101, 32'h0, 32'h0000_9A00, 2, 5'd9, 1,
                  4'b0000, 32'h0, 32'h0000_009A, 0);
    applyStimulus("SB", 0, 1, F3_B, 32'h103, 32'h1234_5678, 32'h0, 0, 5'd0, 1,
                  4'b1000, 32'h7878_7878, 32'h0, 0);
    applyStimulus("illegal f3", 1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 5'd10, 0,
                  4'b0000, 32'h0, 32'h0, 1);
    applyStimulus("ALU op", 0, 0, F3_W, 32'h1234_5678, 32'h0, 32'h0, 0, 5'd11, 0,
                  4'b0000, 32'h0, 32'h0, 0);
    applyStimulus("LW timeout", 1, 0, F3_W, 32'h108, 32'h0, 32'h5555_5555, -1, 5'd12, 1,
                  4'b0000, 32'h0, 32'h0, 1);
    applyStimulus("LW after timeout", 1, 0, F3_W, 32'h10C, 32'h0, 32'hCAFE_F00D, 0, 5'd13, 1,
                  4'b0000, 32'h0, 32'hCAFE_F00D, 0);

    // Reset lands in the second WAIT cycle of a load that never completes
    ex_mem_valid      = 1'b1;
    ex_mem_mem_read   = 1'b1;
    ex_mem_funct3     = F3_W;
    ex_mem_alu_result = 32'h200;
    ex_mem_reg_write  = 1'b1;
    ex_mem_rd         = 5'd14;
    ex_mem_pc_plus_4  = 32'h0000_2000;
    @(negedge clk);
    checkOutput("rstwait idle req", 32'(dmem_req), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("rstwait wait1 req", 32'(dmem_req), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstwait req in reset", 32'(dmem_req), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clearInputs();
    @(negedge clk);
    checkOutput("rstwait req", 32'(dmem_req), 32'd0);
    checkOutput("rstwait stall", 32'(mem_stall), 32'd0);
    checkOutput("rstwait wb_valid", 32'(mem_wb_valid), 32'd0);
    checkOutput("rstwait wb_reg_write", 32'(mem_wb_reg_write), 32'd0);
    checkOutput("rstwait wb_rd", 32'(mem_wb_rd), 32'd0);
    checkOutput("rstwait wb_alu", mem_wb_alu_result, 32'd0);
    checkOutput("rstwait wb_pc", mem_wb_pc_plus_4, 32'd0);
    checkOutput("rstwait wb_load", mem_wb_load_data, 32'd0);
    checkOutput("rstwait fault", 32'(mem_fault_o), 32'd0);
    @(posedge clk);
    #1;

    applyStimulus("SW after reset", 0, 1, F3_W, 32'h300, 32'h0BAD_CAFE, 32'h0, 1, 5'd0, 1,
                  4'b1111, 32'h0BAD_CAFE, 32'h0, 0);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
